// File: rtl/m24c16_responder_pkg.sv
// Shared types and constants for the M24C16 EEPROM responder.
// Holds the protocol FSM states, device code and array geometry.
package m24c16_responder_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEVSEL,
      DEV_ACK,
      ADDR,
      ADDR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } state_t;

   localparam logic [3:0] DEVICE_CODE = 4'b1010;
   localparam int         PAGE_BITS   = 4;
   localparam int         MEM_ADDR_W  = 11;

   // Page-mode writes roll over inside the 16-byte page, upper bits untouched.
   function automatic logic [MEM_ADDR_W-1:0] page_inc(input logic [MEM_ADDR_W-1:0] ptr);
      return {ptr[MEM_ADDR_W-1:PAGE_BITS], ptr[PAGE_BITS-1:0] + 1'b1};
   endfunction

endpackage

// File: rtl/m24c16_responder_if.sv
// Bus bundle between the responder and its surroundings:
// raw I2C lines, open-drain SDA pull, write control and the external RAM port.
interface m24c16_responder_if;
   import m24c16_responder_pkg::*;

   logic                  scl_in;
   logic                  sda_in;
   logic                  sda_pull_low;
   logic                  wc_n;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  mem_we;
   logic [7:0]            mem_rdata;
   logic                  busy;

   modport slave (
      input  scl_in, sda_in, wc_n, mem_rdata,
      output sda_pull_low, mem_addr, mem_wdata, mem_we, busy
   );

   modport master (
      output scl_in, sda_in, wc_n, mem_rdata,
      input  sda_pull_low, mem_addr, mem_wdata, mem_we, busy
   );

endinterface

// File: rtl/m24c16_responder_i2c_line_cond.sv
// Conditions one raw I2C line: 2-flop synchronizer, a run-length glitch
// filter and single-cycle rise/fall pulses on the filtered level.
module i2c_line_cond #(
   parameter int FILTER_LEN = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync1;
   logic             sync2;
   logic             level_d;
   logic [CNT_W-1:0] run_cnt;

   // Idle bus is high, so every stage resets to 1 to avoid a phantom edge.
   // The level only flips after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         run_cnt <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 == level) begin
            run_cnt <= '0;
         end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
            level   <= sync2;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

endmodule

// File: rtl/m24c16_responder.sv
// I2C target emulating an M24C16 EEPROM on top of an external 2048x8
// synchronous RAM; SDA is open-drain and only ever pulled low.
module m24c16_responder
   import m24c16_responder_pkg::*;
#(
   parameter int FILTER_LEN  = 3,
   parameter int HOLD_CYCLES = 4
) (
   input logic                clock,
   input logic                reset,
   m24c16_responder_if.slave  bus
);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   state_t                state, state_nxt;
   logic [2:0]            bit_cnt, bit_cnt_nxt;
   logic [7:0]            shift, shift_nxt;
   logic [MEM_ADDR_W-1:0] pointer, pointer_nxt;
   logic                  byte_done, byte_done_nxt;
   logic                  ack, ack_nxt;
   logic                  rw, rw_nxt;
   logic                  drive, drive_nxt;
   logic                  pend_drive, pend_drive_nxt;
   logic [HOLD_W-1:0]     hold, hold_nxt;
   logic                  we, we_nxt;
   logic [7:0]            wdata, wdata_nxt;
   logic [7:0]            rx_byte;

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;
   logic scl_steady_high, start, stop;

   i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) scl_cond (
      .clock (clock),
      .reset (reset),
      .raw   (bus.scl_in),
      .level (scl_level),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) sda_cond (
      .clock (clock),
      .reset (reset),
      .raw   (bus.sda_in),
      .level (sda_level),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // SDA edges that coincide with an SCL edge are data, never START/STOP.
   assign scl_steady_high = scl_level & ~scl_rise;
   assign start           = sda_fall & scl_steady_high;
   assign stop            = sda_rise & scl_steady_high;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= 3'd7;
         shift      <= '0;
         pointer    <= '0;
         byte_done  <= 1'b0;
         ack        <= 1'b0;
         rw         <= 1'b0;
         drive      <= 1'b0;
         pend_drive <= 1'b0;
         hold       <= '0;
         we         <= 1'b0;
         wdata      <= '0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         pointer    <= pointer_nxt;
         byte_done  <= byte_done_nxt;
         ack        <= ack_nxt;
         rw         <= rw_nxt;
         drive      <= drive_nxt;
         pend_drive <= pend_drive_nxt;
         hold       <= hold_nxt;
         we         <= we_nxt;
         wdata      <= wdata_nxt;
      end
   end

   // Bytes complete on the 8th SCL rise; ACK/data drive changes are queued on
   // SCL falls and applied HOLD_CYCLES later so SDA never moves near SCL high.
   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift;
      pointer_nxt    = pointer;
      byte_done_nxt  = byte_done;
      ack_nxt        = ack;
      rw_nxt         = rw;
      drive_nxt      = drive;
      pend_drive_nxt = pend_drive;
      hold_nxt       = hold;
      we_nxt         = 1'b0;
      wdata_nxt      = wdata;
      rx_byte        = {shift[6:0], sda_level};

      if (we) begin
         pointer_nxt = page_inc(pointer);
      end

      if (hold != '0) begin
         hold_nxt = hold - 1'b1;
         if (hold == HOLD_W'(1)) begin
            drive_nxt = pend_drive;
         end
      end

      if (start) begin
         state_nxt     = DEVSEL;
         bit_cnt_nxt   = 3'd7;
         byte_done_nxt = 1'b0;
         drive_nxt     = 1'b0;
         hold_nxt      = '0;
      end else if (stop) begin
         state_nxt     = IDLE;
         byte_done_nxt = 1'b0;
         drive_nxt     = 1'b0;
         hold_nxt      = '0;
      end else if (scl_rise) begin
         case (state)
            DEVSEL, ADDR, WDATA: begin
               shift_nxt   = rx_byte;
               bit_cnt_nxt = bit_cnt - 1'b1;
               if (bit_cnt == 3'd0) begin
                  byte_done_nxt = 1'b1;
                  ack_nxt       = 1'b1;
                  if (state == DEVSEL) begin
                     if (rx_byte[7:4] == DEVICE_CODE) begin
                        pointer_nxt[MEM_ADDR_W-1:8] = rx_byte[3:1];
                        rw_nxt                      = rx_byte[0];
                     end else begin
                        state_nxt     = IGNORE;
                        byte_done_nxt = 1'b0;
                     end
                  end else if (state == ADDR) begin
                     pointer_nxt[7:0] = rx_byte;
                  end else if (!bus.wc_n) begin
                     we_nxt    = 1'b1;
                     wdata_nxt = rx_byte;
                  end else begin
                     ack_nxt = 1'b0;
                  end
               end
            end
            RDATA: begin
               bit_cnt_nxt = bit_cnt - 1'b1;
               if (bit_cnt == 3'd0) begin
                  byte_done_nxt = 1'b1;
               end
            end
            RDATA_ACK: begin
               if (sda_level) begin
                  state_nxt = IGNORE;
               end else begin
                  byte_done_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state)
            DEVSEL, ADDR, WDATA: begin
               if (byte_done) begin
                  byte_done_nxt  = 1'b0;
                  pend_drive_nxt = ack;
                  hold_nxt       = HOLD_W'(HOLD_CYCLES);
                  state_nxt      = (state == DEVSEL) ? DEV_ACK :
                                   (state == ADDR)   ? ADDR_ACK : WDATA_ACK;
               end
            end
            DEV_ACK: begin
               hold_nxt    = HOLD_W'(HOLD_CYCLES);
               bit_cnt_nxt = 3'd7;
               if (rw) begin
                  state_nxt      = RDATA;
                  shift_nxt      = bus.mem_rdata;
                  pend_drive_nxt = ~bus.mem_rdata[7];
               end else begin
                  state_nxt      = ADDR;
                  pend_drive_nxt = 1'b0;
               end
            end
            ADDR_ACK, WDATA_ACK: begin
               state_nxt      = WDATA;
               bit_cnt_nxt    = 3'd7;
               pend_drive_nxt = 1'b0;
               hold_nxt       = HOLD_W'(HOLD_CYCLES);
            end
            RDATA: begin
               hold_nxt = HOLD_W'(HOLD_CYCLES);
               if (byte_done) begin
                  byte_done_nxt  = 1'b0;
                  pend_drive_nxt = 1'b0;
                  state_nxt      = RDATA_ACK;
                  pointer_nxt    = pointer + 1'b1;
               end else begin
                  shift_nxt      = {shift[6:0], 1'b0};
                  pend_drive_nxt = ~shift[6];
               end
            end
            RDATA_ACK: begin
               if (byte_done) begin
                  byte_done_nxt  = 1'b0;
                  state_nxt      = RDATA;
                  bit_cnt_nxt    = 3'd7;
                  shift_nxt      = bus.mem_rdata;
                  pend_drive_nxt = ~bus.mem_rdata[7];
                  hold_nxt       = HOLD_W'(HOLD_CYCLES);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sda_pull_low = drive;
   assign bus.mem_addr     = pointer;
   assign bus.mem_wdata    = wdata;
   assign bus.mem_we       = we;
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_m24c16_responder.sv
// Directed bench for m24c16_responder: a bit-banged I2C initiator, a
// 2048x8 synchronous RAM model and per-scenario hand-computed checks.
module tb_m24c16_responder;

   localparam int Q = 8;

   logic       clock;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       wc;
   logic [7:0] rdata;
   logic       sda_bus;

   int checks   = 0;
   int failures = 0;
   int drive_cycles = 0;

   logic [7:0]  ram [0:2047];
   logic [10:0] wr_addr_q [$];
   logic [7:0]  wr_data_q [$];

   m24c16_responder_if bus_if ();

   m24c16_responder #(
      .FILTER_LEN  (3),
      .HOLD_CYCLES (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   assign sda_bus          = sda_m & ~bus_if.sda_pull_low;
   assign bus_if.scl_in    = scl_m;
   assign bus_if.sda_in    = sda_bus;
   assign bus_if.wc_n      = wc;
   assign bus_if.mem_rdata = rdata;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model plus a log of every write strobe.
   always @(posedge clock) begin
      if (bus_if.mem_we) begin
         ram[bus_if.mem_addr] <= bus_if.mem_wdata;
         wr_addr_q.push_back(bus_if.mem_addr);
         wr_data_q.push_back(bus_if.mem_wdata);
      end
      rdata <= ram[bus_if.mem_addr];
      if (bus_if.sda_pull_low) drive_cycles++;
   end

   task automatic send_bit(input logic b, output logic s, output logic drv);
      repeat (Q) @(negedge clock);
      sda_m = b;
      repeat (Q) @(negedge clock);
      scl_m = 1'b1;
      repeat (Q) @(negedge clock);
      s   = sda_bus;
      drv = bus_if.sda_pull_low;
      repeat (Q) @(negedge clock);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      repeat (Q) @(negedge clock);
      sda_m = 1'b1;
      repeat (Q) @(negedge clock);
      scl_m = 1'b1;
      repeat (Q) @(negedge clock);
      sda_m = 1'b0;
      repeat (Q) @(negedge clock);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      repeat (Q) @(negedge clock);
      sda_m = 1'b0;
      repeat (Q) @(negedge clock);
      scl_m = 1'b1;
      repeat (Q) @(negedge clock);
      sda_m = 1'b1;
      repeat (2 * Q) @(negedge clock);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic s, drv;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s, drv);
      send_bit(1'b1, s, drv);
      acked = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d, output logic slot_drv);
      logic s, drv;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s, drv);
         d[i] = s;
      end
      send_bit(nack, s, slot_drv);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wc    = 1'b0;
      for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
      repeat (3) @(negedge clock);
      checks++;
      if (bus_if.sda_pull_low !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda: got %b expected 0", bus_if.sda_pull_low); end
      checks++;
      if (bus_if.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", bus_if.mem_we); end
      checks++;
      if (bus_if.mem_addr !== 11'h000) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 000", bus_if.mem_addr); end
      checks++;
      if (bus_if.mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_wdata: got %h expected 00", bus_if.mem_wdata); end
      checks++;
      if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.busy); end
      reset = 1'b0;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_write_single();
      logic a0, a1, a2;
      wr_addr_q.delete();
      wr_data_q.delete();
      i2c_start();
      checks++;
      if (bus_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_after_start: got %b expected 1", bus_if.busy); end
      write_byte(8'hA4, a0);
      write_byte(8'h10, a1);
      write_byte(8'h5A, a2);
      i2c_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin failures++; $display("[TB] FAIL single_acks: got %b expected 111", {a0, a1, a2}); end
      checks++;
      if (wr_addr_q.size() !== 1) begin failures++; $display("[TB] FAIL single_we_count: got %0d expected 1", wr_addr_q.size()); end
      checks++;
      if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 11'hxxx) !== 11'h210) begin failures++; $display("[TB] FAIL single_addr: got %h expected 210", wr_addr_q.size() > 0 ? wr_addr_q[0] : 11'hxxx); end
      checks++;
      if ((wr_data_q.size() > 0 ? wr_data_q[0] : 8'hxx) !== 8'h5A) begin failures++; $display("[TB] FAIL single_data: got %h expected 5a", wr_data_q.size() > 0 ? wr_data_q[0] : 8'hxx); end
      checks++;
      if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after_stop: got %b expected 0", bus_if.busy); end
   endtask

   task automatic test_page_wrap();
      logic a0, a1, a2, a3;
      wr_addr_q.delete();
      wr_data_q.delete();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h0F, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, a3);
      i2c_stop();
      checks++;
      if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("[TB] FAIL wrap_acks: got %b expected 1111", {a0, a1, a2, a3}); end
      checks++;
      if (wr_addr_q.size() !== 2) begin failures++; $display("[TB] FAIL wrap_we_count: got %0d expected 2", wr_addr_q.size()); end
      checks++;
      if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 11'hxxx) !== 11'h00F) begin failures++; $display("[TB] FAIL wrap_addr0: got %h expected 00f", wr_addr_q.size() > 0 ? wr_addr_q[0] : 11'hxxx); end
      checks++;
      if ((wr_addr_q.size() > 1 ? wr_addr_q[1] : 11'hxxx) !== 11'h000) begin failures++; $display("[TB] FAIL wrap_addr1: got %h expected 000", wr_addr_q.size() > 1 ? wr_addr_q[1] : 11'hxxx); end
      checks++;
      if ((wr_data_q.size() > 1 ? {wr_data_q[0], wr_data_q[1]} : 16'hxxxx) !== 16'h1122) begin failures++; $display("[TB] FAIL wrap_data: got %h expected 1122", wr_data_q.size() > 1 ? {wr_data_q[0], wr_data_q[1]} : 16'hxxxx); end
   endtask

   task automatic test_read_wrap();
      logic       a0, a1, a2, d0, d1;
      logic [7:0] r0, r1;
      ram[11'h7FF] = 8'h3C;
      ram[11'h000] = 8'hC3;
      wr_addr_q.delete();
      wr_data_q.delete();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'hFF, a1);
      i2c_start();
      write_byte(8'hAF, a2);
      read_byte(1'b0, r0, d0);
      read_byte(1'b1, r1, d1);
      i2c_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin failures++; $display("[TB] FAIL read_acks: got %b expected 111", {a0, a1, a2}); end
      checks++;
      if (r0 !== 8'h3C) begin failures++; $display("[TB] FAIL read_byte0: got %h expected 3c", r0); end
      checks++;
      if (r1 !== 8'hC3) begin failures++; $display("[TB] FAIL read_byte1: got %h expected c3", r1); end
      checks++;
      if ({d0, d1} !== 2'b00) begin failures++; $display("[TB] FAIL read_ack_slot_drive: got %b expected 00", {d0, d1}); end
      checks++;
      if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL read_we_count: got %0d expected 0", wr_addr_q.size()); end
   endtask

   task automatic test_ignore();
      logic a0, a1;
      wr_addr_q.delete();
      wr_data_q.delete();
      drive_cycles = 0;
      i2c_start();
      write_byte(8'h90, a0);
      write_byte(8'h55, a1);
      checks++;
      if ({a0, a1} !== 2'b00) begin failures++; $display("[TB] FAIL ignore_acks: got %b expected 00", {a0, a1}); end
      checks++;
      if (drive_cycles !== 0) begin failures++; $display("[TB] FAIL ignore_drive: got %0d cycles expected 0", drive_cycles); end
      checks++;
      if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL ignore_we_count: got %0d expected 0", wr_addr_q.size()); end
      i2c_stop();
   endtask

   task automatic test_write_protect();
      logic a0, a1, a2;
      wr_addr_q.delete();
      wr_data_q.delete();
      wc = 1'b1;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h00, a1);
      write_byte(8'h77, a2);
      i2c_stop();
      wc = 1'b0;
      checks++;
      if ({a0, a1, a2} !== 3'b110) begin failures++; $display("[TB] FAIL wc_acks: got %b expected 110", {a0, a1, a2}); end
      checks++;
      if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL wc_we_count: got %0d expected 0", wr_addr_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic       s, drv, a0, a1, a2;
      logic [7:0] dev;
      int         waited;
      dev = 8'hA0;
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(dev[i], s, drv);
      waited = 0;
      while (bus_if.sda_pull_low !== 1'b1 && waited < 40) begin
         @(negedge clock);
         waited++;
      end
      checks++;
      if (bus_if.sda_pull_low !== 1'b1) begin failures++; $display("[TB] FAIL mid_ack_drive: got %b expected 1 within 40 clocks", bus_if.sda_pull_low); end
      reset = 1'b1;
      scl_m = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      scl_m = 1'b0;
      checks++;
      if (bus_if.sda_pull_low !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_release: got %b expected 0", bus_if.sda_pull_low); end
      checks++;
      if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", bus_if.busy); end
      repeat (20) @(negedge clock);
      scl_m = 1'b1;
      @(negedge clock);
      scl_m = 1'b0;
      repeat (20) @(negedge clock);
      checks++;
      if ({bus_if.busy, bus_if.sda_pull_low} !== 2'b00) begin failures++; $display("[TB] FAIL mid_glitch_idle: got busy/sda %b expected 00", {bus_if.busy, bus_if.sda_pull_low}); end
      i2c_stop();
      wr_addr_q.delete();
      wr_data_q.delete();
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h33, a1);
      write_byte(8'h44, a2);
      i2c_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin failures++; $display("[TB] FAIL post_reset_acks: got %b expected 111", {a0, a1, a2}); end
      checks++;
      if ((wr_addr_q.size() == 1 ? {wr_addr_q[0], wr_data_q[0]} : 19'hx) !== {11'h033, 8'h44}) begin failures++; $display("[TB] FAIL post_reset_write: got count %0d expected one write 033<=44", wr_addr_q.size()); end
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_page_wrap();
      test_read_wrap();
      test_ignore();
      test_write_protect();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
